// File: rtl/gerador_eventos.sv
// gerador_eventos: synchronises and debounces the light sensor and push-button, tracks DIA/NOITE
// and emits stretched active-low dawn/dusk/manual request strobes. GERADOR_CONTADOR_EN adds eventos[7:0].
module gerador_eventos #(
  parameter int   LUZ_CYCLES   = 50000000,
  parameter int   BOTAO_CYCLES = 1000000,
  parameter int   PULSE_CYCLES = 5,
  parameter logic INIT_DIA     = 1'b0
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       luz,
  input  logic       botao_n,
  output logic       amanhecer_n,
  output logic       anoitecer_n,
  output logic       controle_n,
`ifdef GERADOR_CONTADOR_EN
  output logic [7:0] eventos,
`endif
  output logic       dia
);

  localparam int LW = $clog2(LUZ_CYCLES + 1);
  localparam int BW = $clog2(BOTAO_CYCLES + 1);
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam logic [LW-1:0] LUZ_MAX      = LW'(LUZ_CYCLES - 1);
  localparam logic [BW-1:0] BOTAO_MAX    = BW'(BOTAO_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_RELOAD = PW'(PULSE_CYCLES - 1);

  typedef enum logic {NOITE = 1'b0, DIA = 1'b1} estado_t;

  logic          luz_meta_r, luz_sync_r, botao_meta_r, botao_sync_r;
  logic          filt_luz_r, filt_botao_r, botao_prev_r;
  logic [LW-1:0] cnt_luz_r;
  logic [BW-1:0] cnt_botao_r;
  logic [PW-1:0] rem_am_r, rem_an_r, rem_ct_r;
  estado_t       estado_r;
  logic          fire_am_s, fire_an_s, fire_ct_s;

  // two-flop synchronisers, preset to the reset-time filtered values
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      luz_meta_r   <= INIT_DIA;
      luz_sync_r   <= INIT_DIA;
      botao_meta_r <= 1'b1;
      botao_sync_r <= 1'b1;
    end else begin
      luz_meta_r   <= luz;
      luz_sync_r   <= luz_meta_r;
      botao_meta_r <= botao_n;
      botao_sync_r <= botao_meta_r;
    end
  end

  // light debounce: accept only after LUZ_CYCLES consecutive differing samples
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      filt_luz_r <= INIT_DIA;
      cnt_luz_r  <= '0;
    end else if (luz_sync_r == filt_luz_r) begin
      cnt_luz_r <= '0;
    end else if (cnt_luz_r == LUZ_MAX) begin
      filt_luz_r <= luz_sync_r;
      cnt_luz_r  <= '0;
    end else begin
      cnt_luz_r <= cnt_luz_r + LW'(1);
    end
  end

  // button debounce: same scheme with BOTAO_CYCLES
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      filt_botao_r <= 1'b1;
      cnt_botao_r  <= '0;
    end else if (botao_sync_r == filt_botao_r) begin
      cnt_botao_r <= '0;
    end else if (cnt_botao_r == BOTAO_MAX) begin
      filt_botao_r <= botao_sync_r;
      cnt_botao_r  <= '0;
    end else begin
      cnt_botao_r <= cnt_botao_r + BW'(1);
    end
  end

  assign fire_am_s = (estado_r == NOITE) && filt_luz_r;
  assign fire_an_s = (estado_r == DIA) && !filt_luz_r;
  assign fire_ct_s = botao_prev_r && !filt_botao_r;
  assign dia       = (estado_r == DIA);

  // day/night FSM and the three pulse stretchers; dawn and dusk cancel each other
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      estado_r     <= estado_t'(INIT_DIA);
      botao_prev_r <= 1'b1;
      amanhecer_n  <= 1'b1;
      anoitecer_n  <= 1'b1;
      controle_n   <= 1'b1;
      rem_am_r     <= '0;
      rem_an_r     <= '0;
      rem_ct_r     <= '0;
    end else begin
      botao_prev_r <= filt_botao_r;
      case (estado_r)
        NOITE:   if (filt_luz_r) estado_r <= DIA;   else estado_r <= NOITE;
        DIA:     if (!filt_luz_r) estado_r <= NOITE; else estado_r <= DIA;
        default: estado_r <= estado_t'(INIT_DIA);
      endcase

      if (fire_am_s) begin
        amanhecer_n <= 1'b0;
        rem_am_r    <= PULSE_RELOAD;
        anoitecer_n <= 1'b1;
        rem_an_r    <= '0;
      end else if (fire_an_s) begin
        anoitecer_n <= 1'b0;
        rem_an_r    <= PULSE_RELOAD;
        amanhecer_n <= 1'b1;
        rem_am_r    <= '0;
      end else begin
        if (rem_am_r != '0) begin
          rem_am_r    <= rem_am_r - PW'(1);
          amanhecer_n <= 1'b0;
        end else begin
          amanhecer_n <= 1'b1;
        end
        if (rem_an_r != '0) begin
          rem_an_r    <= rem_an_r - PW'(1);
          anoitecer_n <= 1'b0;
        end else begin
          anoitecer_n <= 1'b1;
        end
      end

      if (fire_ct_s) begin
        controle_n <= 1'b0;
        rem_ct_r   <= PULSE_RELOAD;
      end else if (rem_ct_r != '0) begin
        rem_ct_r   <= rem_ct_r - PW'(1);
        controle_n <= 1'b0;
      end else begin
        controle_n <= 1'b1;
      end
    end
  end

`ifdef GERADOR_CONTADOR_EN
  // saturating count of dawn and dusk fires
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      eventos <= 8'd0;
    end else if ((fire_am_s || fire_an_s) && (eventos != 8'hFF)) begin
      eventos <= eventos + 8'd1;
    end else begin
      eventos <= eventos;
    end
  end
`endif

endmodule
